// File: rtl/hilo_mult_ctrl_pkg.sv
// Shared types and constants for the HI/LO multiply controller and its
// pipelined unsigned multiplier.
package hilo_mult_ctrl_pkg;

  localparam int DATA_W   = 32;
  localparam int PROD_W   = 64;
  localparam int MULT_LAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  // Magnitude of an operand; 0x80000000 maps to itself as an unsigned value.
  function automatic logic [DATA_W-1:0] op_mag(input logic [DATA_W-1:0] v,
                                                input logic              sgn);
    return (sgn && v[DATA_W-1]) ? ({DATA_W{1'b0}} - v) : v;
  endfunction

  function automatic logic [PROD_W-1:0] neg_prod(input logic [PROD_W-1:0] p);
    return {PROD_W{1'b0}} - p;
  endfunction

endpackage

// File: rtl/hilo_mult_ctrl_umul32_pipe.sv
// Unsigned 32x32->64 multiplier: operands captured on cap_i, product valid
// MULT_LAT cycles later and held until the next capture propagates.
module umul32_pipe
  import hilo_mult_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [PROD_W-1:0] prod_o
);

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] pp [4];
  logic [PROD_W-1:0] sum;
  logic [PROD_W-1:0] stage_q [MULT_LAT-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else if (cap_i) begin
      a_q <= a_i;
      b_q <= b_i;
    end
  end

  // Four 16x16 partial products: pp[gi] = a half (gi%2) x b half (gi/2).
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pp
      assign pp[gi] = {16'b0, a_q[16*(gi%2) +: 16]} * {16'b0, b_q[16*(gi/2) +: 16]};
    end
  endgenerate

  assign sum = {32'b0, pp[0]}
             + ({32'b0, pp[1]} << 16)
             + ({32'b0, pp[2]} << 16)
             + ({32'b0, pp[3]} << 32);

  generate
    for (genvar gi = 0; gi < MULT_LAT - 1; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge reset) begin
          if (reset) stage_q[gi] <= '0;
          else       stage_q[gi] <= sum;
        end
      end else begin : g_rest
        always_ff @(posedge clk or posedge reset) begin
          if (reset) stage_q[gi] <= '0;
          else       stage_q[gi] <= stage_q[gi-1];
        end
      end
    end
  endgenerate

  assign prod_o = stage_q[MULT_LAT-2];

endmodule

// File: rtl/hilo_mult_ctrl.sv
// MIPS-style HI/LO multiply unit: sign handling, FSM sequencing and the
// architectural HI/LO registers around a pipelined unsigned multiplier.
module hilo_mult_ctrl
  import hilo_mult_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              mthi_en,
  input  logic              mtlo_en,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  state_e            state_q;
  logic [DATA_W-1:0] mag_a_q;
  logic [DATA_W-1:0] mag_b_q;
  logic              neg_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              done_q;
  logic [PROD_W-1:0] prod;

  umul32_pipe u_mul (
    .clk    (clk),
    .reset  (reset),
    .cap_i  (state_q == ST_ISSUE),
    .a_i    (mag_a_q),
    .b_i    (mag_b_q),
    .prod_o (prod)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // mt writes land first; a same-cycle multiply overwrites them later.
          if (mthi_en) hi_q <= wdata;
          if (mtlo_en) lo_q <= wdata;
          if (start) begin
            mag_a_q <= op_mag(a, is_signed);
            mag_b_q <= op_mag(b, is_signed);
            neg_q   <= is_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT:  state_q <= ST_WRITE;
        ST_WRITE: begin
          {hi_q, lo_q} <= neg_q ? neg_prod(prod) : prod;
          done_q       <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Directed bench for hilo_mult_ctrl with a queue scoreboard of expected
// {HI,LO} values popped on each done pulse.
module tb_hilo_mult_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi_en;
  logic        mtlo_en;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] hl_exp;

  hilo_mult_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .mthi_en   (mthi_en),
    .mtlo_en   (mtlo_en),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xe;
    logic [63:0] ye;
    xe = s ? {{32{x[31]}}, x} : {32'b0, x};
    ye = s ? {{32{y[31]}}, y} : {32'b0, y};
    return xe * ye;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives start across one edge (E0) and records the expected result.
  task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; is_signed = s; a = x; b = y;
    exp_q.push_back(model(s, x, y));
    step();
    start = 1'b0;
    a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
    $display("txn %s a=%h b=%h", s ? "MULT " : "MULTU", x, y);
  endtask

  // Waits (bounded) for done; rem is the number of busy samples expected before it.
  task automatic wait_done(input string tag, input int rem);
    int nb;
    int lat;
    bit seen;
    nb = 0; lat = 0; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (busy) nb++;
      if (done) seen = 1'b1;
      else begin step(); lat++; end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_busy_cycles"}, 64'(nb), 64'(rem));
    check({tag, "_latency"}, 64'(lat), 64'(rem));
    check({tag, "_sb_depth"}, 64'(exp_q.size()), 64'd1);
    if (seen && exp_q.size() != 0) begin
      hl_exp = exp_q.pop_front();
      check({tag, "_hilo"}, {hi, lo}, hl_exp);
      $display("txn %s result hi=%h lo=%h", tag, hi, lo);
    end
    step();
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
  endtask

  task automatic quiet_cycles(input string tag, input int n);
    int nd;
    int nbz;
    nd = 0; nbz = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (done) nd++;
      if (busy) nbz++;
    end
    check({tag, "_no_done"}, 64'(nd), 64'd0);
    check({tag, "_no_busy"}, 64'(nbz), 64'd0);
  endtask

  logic [31:0] vals [6];

  initial begin
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    mthi_en = 1'b0; mtlo_en = 1'b0; wdata = '0;
    hl_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    step();

    issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu_ffff", 3);
    check("multu_ffff_const", {hi, lo}, 64'hFFFFFFFE_00000001);

    issue(1'b1, 32'hFFFFFFFD, 32'd5);
    wait_done("mult_m3x5", 3);
    check("mult_m3x5_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);

    issue(1'b1, 32'h80000000, 32'h80000000);
    wait_done("mult_minmin", 3);
    check("mult_minmin_const", {hi, lo}, 64'h40000000_00000000);

    issue(1'b0, 32'h80000000, 32'd2);
    wait_done("multu_min2", 3);
    check("multu_min2_const", {hi, lo}, 64'h00000001_00000000);

    // mtlo in IDLE
    mtlo_en = 1'b1; wdata = 32'hAAAA5555;
    step();
    mtlo_en = 1'b0;
    check("mtlo_lo", 64'(lo), 64'hAAAA5555);
    check("mtlo_hi_kept", 64'(hi), 64'(hl_exp[63:32]));
    check("mtlo_busy", 64'(busy), 64'd0);
    hl_exp[31:0] = 32'hAAAA5555;
    $display("txn MTLO wdata=aaaa5555");

    // mthi and mtlo together
    mthi_en = 1'b1; mtlo_en = 1'b1; wdata = 32'h0BADBEEF;
    step();
    mthi_en = 1'b0; mtlo_en = 1'b0;
    check("mtboth", {hi, lo}, 64'h0BADBEEF_0BADBEEF);
    hl_exp = 64'h0BADBEEF_0BADBEEF;
    $display("txn MTHI+MTLO wdata=0badbeef");

    // start and mthi in the same IDLE cycle
    mthi_en = 1'b1; wdata = 32'hCAFEF00D;
    issue(1'b0, 32'd7, 32'd9);
    mthi_en = 1'b0;
    check("mt_start_hi", 64'(hi), 64'hCAFEF00D);
    check("mt_start_lo", 64'(lo), 64'(hl_exp[31:0]));
    wait_done("mt_start_mul", 3);
    check("mt_start_const", {hi, lo}, 64'd63);

    // start at E1 and mthi at E2 are ignored while busy
    issue(1'b1, 32'h12345678, 32'hFEDCBA98);
    start = 1'b1; is_signed = 1'b0; a = 32'h11111111; b = 32'h22222222;
    step();
    start = 1'b0; mthi_en = 1'b1; wdata = 32'h00001234;
    step();
    mthi_en = 1'b0;
    check("busy_mthi_ignored", 64'(hi), 64'(hl_exp[63:32]));
    wait_done("busy_ignore", 1);
    quiet_cycles("no_queue", 4);

    // reset between E1 and E2
    issue(1'b0, 32'hDEADBEEF, 32'h01234567);
    step();
    reset = 1'b1;
    #1;
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    exp_q.delete();
    #1;
    reset = 1'b0;
    quiet_cycles("midrst", 5);
    check("midrst_hilo_held", {hi, lo}, 64'd0);
    $display("txn RESET mid-operation");

    issue(1'b1, 32'h00000000, 32'h80000000);
    wait_done("post_rst", 3);

    vals[0] = 32'h00000000; vals[1] = 32'hFFFFFFFF; vals[2] = 32'h80000000;
    vals[3] = 32'h00000001; vals[4] = 32'h7FFFFFFF; vals[5] = 32'h0;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] x;
      logic [31:0] y;
      vals[5] = $urandom;
      x = vals[$urandom_range(0, 5)];
      y = (i % 2 == 0) ? vals[$urandom_range(0, 5)] : $urandom;
      issue(1'($urandom_range(0, 1)), x, y);
      wait_done("mix", 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
